// File: rtl/mips_multicycle_sequencer_if.sv
// Control bundle between the MIPS sequencer (master) and the datapath/memories (slave).
// Inputs to the sequencer are status/handshake returns; outputs are strobes, selects and status.
interface mips_multicycle_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic               start;
  logic [5:0]         opcode;
  logic               alu_zero;
  logic               imem_ready;
  logic               dmem_ready;
  logic               imem_req;
  logic               ir_write;
  logic               dmem_req;
  logic               dmem_we;
  logic               reg_write;
  logic               reg_dst;
  logic               alu_source;
  logic               mem_to_reg;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic [2:0]         state;
  logic               illegal_op;
  logic               timeout;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  start, opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, dmem_we, reg_write, reg_dst, alu_source,
           mem_to_reg, pc_write, pc_src, state, illegal_op, timeout, instr_count
  );

  modport slave (
    output start, opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, dmem_we, reg_write, reg_dst, alu_source,
           mem_to_reg, pc_write, pc_src, state, illegal_op, timeout, instr_count
  );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback strobes, 3-5 cycles per instruction at zero wait.
// Memory stalls hold req until ready; a stall reaching MEM_TIMEOUT cycles parks the FSM in FAULT until reset.
module mips_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input logic                         clk,
  input logic                         rst_n,
  mips_multicycle_sequencer_if.master seq_io
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_e;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BNE) || (op[5:3] == 3'b001) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               ir_write_q, ir_write_d;
  logic               sw_done_q, sw_done_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic       imem_req, dmem_req, dmem_we, reg_write, reg_dst, alu_source, mem_to_reg;
  logic       pc_write_fsm, pc_write;
  logic [1:0] pc_src;
  state_e     boundary;

  logic is_r, is_j, is_bne, is_imm, is_lw, is_sw;
  assign is_r   = (op_q == OP_R);
  assign is_j   = (op_q == OP_J);
  assign is_bne = (op_q == OP_BNE);
  assign is_imm = (op_q[5:3] == 3'b001);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);

  // Stop requests take effect only here, so an in-flight instruction always retires.
  assign boundary = seq_io.start ? S_FETCH : S_IDLE;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = wait_q;
    ir_write_d   = 1'b0;
    sw_done_d    = 1'b0;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    alu_source   = 1'b0;
    mem_to_reg   = 1'b0;
    pc_write_fsm = 1'b0;
    pc_src       = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (seq_io.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (seq_io.imem_ready) begin
          ir_write_d = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = seq_io.opcode;
        if (op_legal(seq_io.opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FAULT;
        end
      end
      S_EXEC: begin
        reg_dst    = is_r;
        alu_source = is_imm || is_lw || is_sw;
        if (is_j) begin
          pc_write_fsm = 1'b1;
          pc_src       = 2'b10;
          state_d      = boundary;
        end else if (is_bne) begin
          // alu_zero only steers the PC mux; the load strobe itself is state-decoded.
          pc_write_fsm = 1'b1;
          pc_src       = seq_io.alu_zero ? 2'b00 : 2'b01;
          state_d      = boundary;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = is_sw;
        alu_source = 1'b1;
        if (seq_io.dmem_ready) begin
          if (is_sw) begin
            sw_done_d = 1'b1;
            state_d   = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write    = 1'b1;
        reg_dst      = is_r;
        alu_source   = is_imm || is_lw;
        mem_to_reg   = is_lw;
        pc_write_fsm = 1'b1;
        state_d      = boundary;
      end
      S_FAULT: begin
      end
      default: state_d = S_FAULT;
    endcase

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) wait_d = '0;
  end

  // The sw completion is ready-dependent, so its PC pulse is registered and lands one cycle later.
  assign pc_write = pc_write_fsm || sw_done_q;
  assign count_d  = count_q + COUNT_W'(pc_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wait_q     <= '0;
      ir_write_q <= 1'b0;
      sw_done_q  <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_q     <= wait_d;
      ir_write_q <= ir_write_d;
      sw_done_q  <= sw_done_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
    end
  end

  assign seq_io.imem_req    = imem_req;
  assign seq_io.ir_write    = ir_write_q;
  assign seq_io.dmem_req    = dmem_req;
  assign seq_io.dmem_we     = dmem_we;
  assign seq_io.reg_write   = reg_write;
  assign seq_io.reg_dst     = reg_dst;
  assign seq_io.alu_source  = alu_source;
  assign seq_io.mem_to_reg  = mem_to_reg;
  assign seq_io.pc_write    = pc_write;
  assign seq_io.pc_src      = pc_src;
  assign seq_io.state       = state_q;
  assign seq_io.illegal_op  = illegal_q;
  assign seq_io.timeout     = timeout_q;
  assign seq_io.instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Bench for mips_multicycle_sequencer: directed and random instruction streams against a per-instruction cycle-trace model.
module tb_mips_multicycle_sequencer;
  localparam int T  = 4;
  localparam int CW = 4;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3, S_M = 3'd4, S_W = 3'd5, S_X = 3'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2b;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_sequencer_if #(.COUNT_W(CW)) bus ();
  mips_multicycle_sequencer #(.MEM_TIMEOUT(T), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_io(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [5:0]    cur_op  = 6'h00;
  logic [CW-1:0] exp_cnt = '0;
  bit exp_ill = 0, exp_to = 0, pend_pc = 0, faulted = 0, idle = 1;

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_J || op == OP_BNE || (op >= 6'h08 && op <= 6'h0f) ||
           op == OP_LW || op == OP_SW;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, then compare every output against the expectation for this cycle.
  task automatic step(input logic [2:0] est, input bit ir, input bit pcw, input logic [1:0] pcs,
                      input bit st, input bit i_rdy, input bit d_rdy, input bit az);
    bit r, imm, lw, sw, live;
    @(negedge clk);
    bus.start      = st;
    bus.imem_ready = i_rdy;
    bus.dmem_ready = d_rdy;
    bus.alu_zero   = az;
    bus.opcode     = cur_op;
    #1;
    r    = (cur_op == OP_R);
    imm  = (cur_op >= 6'h08 && cur_op <= 6'h0f);
    lw   = (cur_op == OP_LW);
    sw   = (cur_op == OP_SW);
    live = (est == S_E) || (est == S_M) || (est == S_W);
    chk("state", 32'(bus.state), 32'(est));
    chk("strobes",
        32'({bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we, bus.reg_write, bus.mem_to_reg,
             bus.pc_write, bus.pc_src, bus.reg_dst, bus.alu_source}),
        32'({est == S_F, ir, est == S_M, (est == S_M) && sw, est == S_W, (est == S_W) && lw,
             pcw, pcs, live && r, live && (imm || lw || sw)}));
    chk("flags", 32'({bus.illegal_op, bus.timeout}), 32'({exp_ill, exp_to}));
    chk("count", 32'(bus.instr_count), 32'(exp_cnt));
    if (pcw) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic reset_now();
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.alu_zero   = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 32'(S_I));
    chk("rst_outs",
        32'({bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we, bus.reg_write, bus.reg_dst,
             bus.alu_source, bus.mem_to_reg, bus.pc_write, bus.pc_src, bus.illegal_op, bus.timeout,
             bus.instr_count}), 32'd0);
    exp_cnt = '0; exp_ill = 0; exp_to = 0; pend_pc = 0; faulted = 0; idle = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_now();
  endtask

  // Expected trace of one instruction starting in FETCH; wf/wm are ready delays in fetch/mem.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit az, input bit st_end);
    bit sw;
    sw     = (op == OP_SW);
    cur_op = op;
    for (int i = 0; i < T; i++) begin
      step(S_F, 0, pend_pc, 2'b00, 1, i == wf, 0, az);
      pend_pc = 0;
      if (i == wf) break;
      if (i == T - 1) begin exp_to = 1; faulted = 1; return; end
    end
    step(S_D, 1, 0, 2'b00, 1, 0, 0, az);
    if (!is_legal(op)) begin exp_ill = 1; faulted = 1; return; end
    if (op == OP_J) begin
      step(S_E, 0, 1, 2'b10, st_end, 0, 0, az);
    end else if (op == OP_BNE) begin
      step(S_E, 0, 1, az ? 2'b00 : 2'b01, st_end, 0, 0, az);
    end else begin
      step(S_E, 0, 0, 2'b00, 1, 0, 0, az);
      if (op == OP_LW || sw) begin
        for (int i = 0; i < T; i++) begin
          step(S_M, 0, 0, 2'b00, sw ? st_end : 1'b1, 0, i == wm, az);
          if (i == wm) break;
          if (i == T - 1) begin exp_to = 1; faulted = 1; return; end
        end
      end
      if (sw) pend_pc = 1;
      else step(S_W, 0, 1, 2'b00, st_end, 0, 0, az);
    end
  endtask

  task automatic instr(input logic [5:0] op, input int wf, input int wm, input bit az, input bit st_end);
    if (idle) step(S_I, 0, 0, 2'b00, 1, 0, 0, 0);
    run_instr(op, wf, wm, az, st_end);
    if (faulted) begin
      repeat (3) step(S_X, 0, 0, 2'b00, 1, 1, 1, 1);
    end else if (!st_end) begin
      step(S_I, 0, pend_pc, 2'b00, 0, 1, 1, 0);
      pend_pc = 0;
    end
    idle = !st_end;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{OP_R, OP_J, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    bus.start = 0; bus.opcode = '0; bus.alu_zero = 0; bus.imem_ready = 0; bus.dmem_ready = 0;

    do_reset();
    instr(OP_ADDI, 0, 0, 0, 1);
    instr(OP_LW, 0, 3, 0, 1);
    instr(OP_BNE, 0, 0, 0, 1);
    instr(OP_BNE, 0, 0, 1, 1);
    instr(OP_SW, 0, 1, 0, 0);
    instr(OP_R, 1, 0, 0, 1);
    instr(OP_J, 2, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == OP_ADDI) op = 6'(8 + $urandom_range(0, 7));
      instr(op, int'($urandom_range(0, T - 1)), int'($urandom_range(0, T - 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    // Reset while a lw is stalled in MEM.
    do_reset();
    step(S_I, 0, 0, 2'b00, 1, 0, 0, 0);
    cur_op = OP_LW;
    step(S_F, 0, 0, 2'b00, 1, 1, 0, 0);
    step(S_D, 1, 0, 2'b00, 1, 0, 0, 0);
    step(S_E, 0, 0, 2'b00, 1, 0, 0, 0);
    step(S_M, 0, 0, 2'b00, 1, 0, 0, 0);
    reset_now();

    instr(OP_SW, 0, T, 0, 1);
    do_reset();
    instr(OP_ADDI, 0, 0, 0, 1);
    instr(6'h3f, 0, 0, 0, 1);
    do_reset();
    instr(OP_R, T, 0, 0, 1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
